// File: rtl/case_9_prod_accum_pkg.sv
// Shared types and constants for the case_9 product accumulator.
package case_9_prod_accum_pkg;

  localparam int DIN_W_DEF     = 9;
  localparam int ACC_W_DEF     = 16;
  localparam int FRAME_LEN_DEF = 8;
  localparam int CNT_W_DEF     = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  function automatic logic signed [63:0] acc_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] acc_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/case_9_sat_add.sv
// Signed accumulator adder with sign-extended narrow operand; saturates when
// CASE_9_PROD_ACCUM_SAT_EN is defined, otherwise wraps.
module case_9_sat_add
  import case_9_prod_accum_pkg::*;
#(
  parameter int DIN_WIDTH = DIN_W_DEF,
  parameter int ACC_WIDTH = ACC_W_DEF
) (
  input  logic signed [ACC_WIDTH-1:0] i_acc,
  input  logic signed [DIN_WIDTH-1:0] i_din,
  output logic signed [ACC_WIDTH-1:0] o_sum,
  output logic                        o_ovf
);

  logic signed [ACC_WIDTH:0] w_sum;

  // One guard bit is enough: a single add cannot exceed ACC_WIDTH+1 bits.
  assign w_sum = {i_acc[ACC_WIDTH-1], i_acc}
               + {{(ACC_WIDTH + 1 - DIN_WIDTH){i_din[DIN_WIDTH-1]}}, i_din};
  assign o_ovf = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];

`ifdef CASE_9_PROD_ACCUM_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] MAX_V = ACC_WIDTH'(acc_max(ACC_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] MIN_V = ACC_WIDTH'(acc_min(ACC_WIDTH));

  always_comb begin
    o_sum = w_sum[ACC_WIDTH-1:0];
    if (o_ovf) o_sum = w_sum[ACC_WIDTH] ? MIN_V : MAX_V;
  end
`else
  assign o_sum = w_sum[ACC_WIDTH-1:0];
`endif

endmodule

// File: rtl/case_9_prod_accum.sv
// Frame accumulator for the case_9 product stream: one signed sum per
// FRAME_LEN beats. Saturation build selected by CASE_9_PROD_ACCUM_SAT_EN.
//
// state | meaning
// ACCUM | accepting products, summing into r_acc
// HOLD  | frame sum presented, waiting for out_ready
module case_9_prod_accum
  import case_9_prod_accum_pkg::*;
#(
  parameter int DIN_WIDTH = DIN_W_DEF,
  parameter int ACC_WIDTH = ACC_W_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int CNT_WIDTH = CNT_W_DEF
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic signed [DIN_WIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_ovf
);

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(FRAME_LEN - 1);

  state_t                      r_state;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0]        r_cnt;
  logic                        r_ovf;
  logic signed [ACC_WIDTH-1:0] r_out_data;
  logic                        r_out_ovf;
  logic                        r_out_valid;

  logic signed [ACC_WIDTH-1:0] w_sum;
  logic                        w_ovf;

  case_9_sat_add #(
    .DIN_WIDTH(DIN_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_add (
    .i_acc(r_acc),
    .i_din(in_data),
    .o_sum(w_sum),
    .o_ovf(w_ovf)
  );

  assign in_ready  = (r_state == ACCUM);
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;
  assign out_valid = r_out_valid;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (in_valid) begin
            if (r_cnt == LAST_BEAT) begin
              r_out_data  <= w_sum;
              r_out_ovf   <= r_ovf | w_ovf;
              r_out_valid <= 1'b1;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_ovf       <= 1'b0;
              r_state     <= HOLD;
            end else begin
              r_acc <= w_sum;
              r_cnt <= r_cnt + CNT_WIDTH'(1);
              r_ovf <= r_ovf | w_ovf;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule

// File: doc/case_9_prod_accum.md
Name: case_9_prod_accum

Overview:
- Downstream consumer of the case_9 signed 9s x 8s -> 9 multiplier product stream.
- Accumulates fixed-length frames of signed products into a wider register and emits one sum per frame.
- Valid/ready on both sides; sits between the multiplier output register and the result writeback stage.

Parameters:
DIN_WIDTH, 9, signed product width from the multiplier
ACC_WIDTH, 16, signed accumulator and output width; must be >= DIN_WIDTH
FRAME_LEN, 8, number of products per frame; legal range 1..65535
CNT_WIDTH, 16, beat counter width; must hold FRAME_LEN-1

Ports:
ap_clk  in  1  clock; all state updates on rising edge
ap_rst  in  1  synchronous, active-high reset
in_data  in  DIN_WIDTH  signed product
in_valid  in  1  in_data is valid
in_ready  out  1  block accepts in_data this cycle
out_data  out  ACC_WIDTH  signed frame sum
out_valid  out  1  out_data and out_ovf are valid
out_ready  in  1  downstream accepts out_data
out_ovf  out  1  overflow occurred during this frame (sticky per frame)

Behaviour:
- Reset, sampled at a clock edge with ap_rst=1:
  - state=ACCUM, acc=0, cnt=0, ovf_r=0.
  - out_valid=0, out_data=0, out_ovf=0.
  - Reset mid-frame or mid-HOLD discards all partial or pending results.
- Input handshake: a beat is accepted when in_valid && in_ready. in_ready = (state==ACCUM); it is combinational on state only, never on in_valid.
- ACCUM state, on each accepted beat:
  - sum = acc + sign_extend(in_data) to ACC_WIDTH+1 bits.
  - Overflow when sum is outside the signed ACC_WIDTH range; this sets ovf_r.
  - If cnt < FRAME_LEN-1: acc <= sum (saturated or wrapped, see Optional Feature); cnt <= cnt+1.
  - If cnt == FRAME_LEN-1 (last beat of frame): out_data <= sum; out_ovf <= ovf_r | this beat's overflow; out_valid <= 1; acc <= 0; cnt <= 0; ovf_r <= 0; state <= HOLD.
- HOLD state:
  - in_ready=0; out_data and out_ovf are held stable.
  - On out_valid && out_ready: out_valid <= 0, state <= ACCUM.
  - The next input can be accepted in the cycle after the output handshake.
- Latency: out_valid rises on the cycle after the last accepted beat. Throughput is FRAME_LEN beats plus 1 handshake cycle per frame minimum.
- Boundaries:
  - in_valid=0 cycles leave acc and cnt unchanged (bubbles allowed).
  - FRAME_LEN=1: every accepted beat produces an output.
  - out_ready held low: block stalls indefinitely in HOLD with no data loss.
  - out_ready high while in ACCUM is ignored.

Optional Feature:
- Macro CASE_9_PROD_ACCUM_SAT_EN.
- Defined: on overflow, acc and out_data clamp to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1) according to the sign of the true sum.
- Undefined: two's-complement wrap (truncate sum to ACC_WIDTH).
- out_ovf is reported identically in both builds.

Decomposition:
- Package case_9_prod_accum_pkg:
  - state enum {ACCUM, HOLD}.
  - ACC_MAX and ACC_MIN constant functions.
  - Default width constants.
- Sub-module case_9_sat_add: combinational ACC_WIDTH signed adder with sign-extended DIN_WIDTH operand. Returns result (sat or wrap per macro) and ovf.

Test Plan:
1. Reset then 8 beats of +3 with in_valid=1 and out_ready=1 -> out_valid rises one cycle after the 8th beat; out_data=24, out_ovf=0; in_ready=0 for exactly that cycle.
2. Beats -256 x8 with bubbles inserted between beats -> out_data=-2048, out_ovf=0; cnt unaffected by bubbles.
3. ACC_WIDTH=10, 8 beats of +255 -> SAT_EN build: out_data=511, out_ovf=1. Wrap build: out_data=2040 mod 1024 = 1016, read as signed -8, out_ovf=1.
4. out_ready=0 for 5 cycles after the frame completes -> out_valid and out_data held stable, in_ready=0 throughout; after out_ready=1, next frame's first beat is accepted the following cycle.
5. Assert ap_rst after 4 of 8 beats of +10, then 8 beats of +1 -> out_data=8 (partial sum discarded), out_ovf=0.
6. FRAME_LEN=1, beats 5, -7, 100 with out_ready=1 -> outputs 5, -7, 100, each one cycle after its accept, with in_ready low for one cycle between beats.
